// File: rtl/rs232_pixel_receiver_pkg.sv
// Shared definitions for the RS232 pixel receiver: UART register map, status bit
// positions and the bus-sequencer state encoding.
package rs232_pkg;

   localparam logic [4:0] RX_ADDR   = 5'd0;
   localparam logic [4:0] TX_ADDR   = 5'd4;
   localparam logic [4:0] STAT_ADDR = 5'd8;

   localparam int RX_RDY_BIT = 7;
   localparam int TX_RDY_BIT = 6;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RD_STAT   = 3'd1,
      S_RD_RX     = 3'd2,
      S_RD_TXSTAT = 3'd3,
      S_WR_TX     = 3'd4
   } state_t;

endpackage

// File: rtl/rs232_pixel_receiver_fifo.sv
// First-word-fall-through pixel FIFO; the head word is visible on o_dout whenever
// the FIFO is non-empty and reads as zero when it is empty.
module pix_fifo #(
   parameter  int PIXEL_W    = 8,
   parameter  int FIFO_DEPTH = 16,
   localparam int AW         = $clog2(FIFO_DEPTH),
   localparam int LW         = AW + 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic [PIXEL_W-1:0] i_din,
   output logic [PIXEL_W-1:0] o_dout,
   output logic               o_full,
   output logic               o_empty,
   output logic [LW-1:0]      o_level
);

   logic [PIXEL_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]      r_wrPtr;
   logic [AW-1:0]      r_rdPtr;
   logic [LW-1:0]      r_level;
   logic               w_doPush;
   logic               w_doPop;

   assign o_empty  = (r_level == '0);
   assign o_full   = (r_level == LW'(FIFO_DEPTH));
   assign o_level  = r_level;
   assign w_doPop  = i_pop & ~o_empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign w_doPush = i_push & (~o_full | w_doPop);
   assign o_dout   = o_empty ? '0 : r_mem[r_rdPtr];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_din;
      end
   end

endmodule

// File: rtl/rs232_pixel_receiver.sv
// Avalon-MM master that polls an RS232 UART, assembles bytes into pixels, buffers
// them in a FWFT FIFO and streams them out with frame-boundary markers.
module rs232_pixel_receiver
   import rs232_pkg::*;
#(
   parameter  int BYTES_PER_PIX = 1,
   parameter  int FIFO_DEPTH    = 16,
   parameter  int FRAME_PIX     = 307200,
   parameter  int ECHO_EN       = 0,
   localparam int PIXEL_W       = 8 * BYTES_PER_PIX,
   localparam int LW            = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               avm_clk,
   input  logic               avm_rst,
   output logic [4:0]         avm_address,
   output logic               avm_read,
   input  logic [31:0]        avm_readdata,
   output logic               avm_write,
   output logic [31:0]        avm_writedata,
   input  logic               avm_waitrequest,
   output logic [PIXEL_W-1:0] o_pix_data,
   output logic               o_pix_valid,
   input  logic               i_pix_ready,
   output logic               o_pix_last,
   output logic               o_frame_done,
   output logic [LW-1:0]      o_fifo_level
);

   localparam int              FCW        = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
   localparam logic [FCW-1:0]  FRAME_LAST = FCW'(FRAME_PIX - 1);
   localparam logic [2:0]      BYTE_LAST  = 3'(BYTES_PER_PIX - 1);

   state_t             r_state;
   state_t             w_stateNext;
   logic [PIXEL_W-1:0] r_asm;
   logic [PIXEL_W-1:0] w_asmNext;
   logic [2:0]         r_byteCnt;
   logic               r_push;
   logic [7:0]         r_echoByte;
   logic [FCW-1:0]     r_frameCnt;

   logic               w_done;
   logic               w_rxDone;
   logic [7:0]         w_rxByte;
   logic               w_pop;
   logic               w_empty;
   logic               w_full;
   logic [LW-1:0]      w_level;
   logic [LW:0]        w_levelAfter;
   logic               w_canFetch;
   logic               w_unused;

   assign w_done   = ~avm_waitrequest;
   assign w_rxByte = avm_readdata[7:0];
   assign w_rxDone = (r_state == S_RD_RX) & w_done;
   assign w_pop    = o_pix_valid & i_pix_ready;
   assign w_unused = &{1'b0, avm_readdata[31:8], w_full};

   // Look ahead past a pixel push still in flight so a fetch never overfills the FIFO.
   assign w_levelAfter = {1'b0, w_level} + {{LW{1'b0}}, r_push} - {{LW{1'b0}}, w_pop};
   assign w_canFetch   = (w_levelAfter < (LW + 1)'(FIFO_DEPTH));

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_canFetch) begin
               w_stateNext = S_RD_STAT;
            end
         end
         S_RD_STAT: begin
            if (w_done) begin
               w_stateNext = avm_readdata[RX_RDY_BIT] ? S_RD_RX : S_IDLE;
            end
         end
         S_RD_RX: begin
            if (w_done) begin
               w_stateNext = (ECHO_EN != 0) ? S_RD_TXSTAT : S_IDLE;
            end
         end
         S_RD_TXSTAT: begin
            if (w_done && avm_readdata[TX_RDY_BIT]) begin
               w_stateNext = S_WR_TX;
            end
         end
         S_WR_TX: begin
            if (w_done) begin
               w_stateNext = S_IDLE;
            end
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Bus strobes are decoded from the state, so they hold steady through any stall.
   always_comb begin
      avm_address   = '0;
      avm_read      = 1'b0;
      avm_write     = 1'b0;
      avm_writedata = '0;
      case (r_state)
         S_RD_STAT, S_RD_TXSTAT: begin
            avm_address = STAT_ADDR;
            avm_read    = 1'b1;
         end
         S_RD_RX: begin
            avm_address = RX_ADDR;
            avm_read    = 1'b1;
         end
         S_WR_TX: begin
            avm_address   = TX_ADDR;
            avm_write     = 1'b1;
            avm_writedata = {24'h0, r_echoByte};
         end
         default: ;
      endcase
   end

   generate
      if (BYTES_PER_PIX == 1) begin : g_asmSingle
         assign w_asmNext = w_rxByte;
      end else begin : g_asmShift
         assign w_asmNext = {r_asm[PIXEL_W-9:0], w_rxByte};
      end
   endgenerate

   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         r_asm      <= '0;
         r_byteCnt  <= '0;
         r_push     <= 1'b0;
         r_echoByte <= '0;
      end else begin
         r_push <= 1'b0;
         if (w_rxDone) begin
            r_asm      <= w_asmNext;
            r_echoByte <= w_rxByte;
            if (r_byteCnt == BYTE_LAST) begin
               r_byteCnt <= '0;
               r_push    <= 1'b1;
            end else begin
               r_byteCnt <= r_byteCnt + 1'b1;
            end
         end
      end
   end

   pix_fifo #(
      .PIXEL_W    (PIXEL_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (avm_clk),
      .i_rst_n (avm_rst),
      .i_push  (r_push),
      .i_pop   (w_pop),
      .i_din   (r_asm),
      .o_dout  (o_pix_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign o_pix_valid  = ~w_empty;
   assign o_fifo_level = w_level;

   always_ff @(posedge avm_clk or negedge avm_rst) begin
      if (!avm_rst) begin
         r_frameCnt <= '0;
      end else if (w_pop) begin
         r_frameCnt <= (r_frameCnt == FRAME_LAST) ? '0 : r_frameCnt + 1'b1;
      end
   end

   assign o_pix_last   = o_pix_valid & (r_frameCnt == FRAME_LAST);
   assign o_frame_done = w_pop & o_pix_last;

endmodule

// File: tb/tb_rs232_pixel_receiver.sv
// Directed bench: a behavioural UART slave on the Avalon side and a pixel sink,
// with 3-byte pixels, a 4-deep FIFO, 4-pixel frames and echo enabled.
module tb_rs232_pixel_receiver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;
   logic [23:0] pixData;
   logic        pixValid;
   logic        pixReady = 1'b0;
   logic        pixLast;
   logic        frameDone;
   logic [2:0]  fifoLevel;

   logic [7:0]  rxQ[$];
   logic [31:0] wrLog[$];
   int          txAtWr[$];
   logic [23:0] popQ[$];

   int          rxHold = 0;
   int          txHold = 0;
   int          stallCycles = 0;
   int          stall = 0;
   bit          inEcho = 0;
   logic        waitReq = 1'b0;
   logic [31:0] rdData = 32'h0;
   int          statReads = 0;
   int          txStatReads = 0;
   int          rxReads = 0;
   int          lastRxCycle = 0;
   int          cycleCnt = 0;
   int          validRiseCycle = 0;
   int          stableErr = 0;
   int          bothErr = 0;
   int          wrAddrErr = 0;
   int          badRdErr = 0;
   logic [4:0]  capAddr = '0;
   logic        capRd = 1'b0;
   logic        capWr = 1'b0;
   logic [31:0] capWd = '0;
   bit          prevValid = 0;
   int          popIdx = 0;
   int          doneTotal = 0;
   logic [15:0] doneBits = '0;
   logic [15:0] lastBits = '0;
   int          compared = 0;
   int          mismatched = 0;

   assign avm_waitrequest = waitReq;
   assign avm_readdata    = rdData;

   always #5 clk = ~clk;

   rs232_pixel_receiver #(
      .BYTES_PER_PIX (3),
      .FIFO_DEPTH    (4),
      .FRAME_PIX     (4),
      .ECHO_EN       (1)
   ) dut (
      .avm_clk         (clk),
      .avm_rst         (rst_n),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .o_pix_data      (pixData),
      .o_pix_valid     (pixValid),
      .i_pix_ready     (pixReady),
      .o_pix_last      (pixLast),
      .o_frame_done    (frameDone),
      .o_fifo_level    (fifoLevel)
   );

   // UART slave and pixel sink: decide waitrequest/readdata mid-cycle, retire
   // transfers that will complete on the next rising edge, and log popped pixels.
   always @(negedge clk) begin
      cycleCnt++;
      if (!rst_n) begin
         waitReq = 1'b0;
         stall   = 0;
         inEcho  = 0;
      end else if (avm_read || avm_write) begin
         if (avm_read && avm_write) bothErr++;
         if (stall == 0) begin
            capAddr = avm_address;
            capRd   = avm_read;
            capWr   = avm_write;
            capWd   = avm_writedata;
         end else if (capAddr != avm_address || capRd != avm_read ||
                      capWr != avm_write || capWd != avm_writedata) begin
            stableErr++;
         end
         if (stall < stallCycles) begin
            waitReq = 1'b1;
            stall++;
         end else begin
            waitReq = 1'b0;
            stall   = 0;
            if (avm_read && avm_address == 5'd8) begin
               statReads++;
               if (inEcho) begin
                  txStatReads++;
                  rdData = {24'hABCDEF, 1'b0, (txHold == 0), 6'h0};
                  if (txHold > 0) txHold--;
               end else begin
                  rdData = {24'hABCDEF, (rxHold == 0 && rxQ.size() > 0), 1'b1, 6'h0};
                  if (rxHold > 0) rxHold--;
               end
            end else if (avm_read && avm_address == 5'd0) begin
               rxReads++;
               lastRxCycle = cycleCnt;
               if (rxQ.size() > 0) rdData = {24'hABCDEF, rxQ.pop_front()};
               else begin
                  rdData = 32'hDEAD00EE;
                  badRdErr++;
               end
               inEcho = 1;
            end else if (avm_write) begin
               wrLog.push_back(avm_writedata);
               txAtWr.push_back(txStatReads);
               if (avm_address != 5'd4) wrAddrErr++;
               inEcho = 0;
            end else begin
               rdData = 32'h0;
               badRdErr++;
            end
         end
      end else begin
         waitReq = 1'b0;
         stall   = 0;
      end

      if (pixValid && !prevValid) validRiseCycle = cycleCnt;
      prevValid = pixValid;
      if (frameDone) doneTotal++;
      if (pixValid && pixReady) begin
         popQ.push_back(pixData);
         if (popIdx < 16) begin
            doneBits[popIdx] = frameDone;
            lastBits[popIdx] = pixLast;
         end
         popIdx++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      rxQ.push_back(b);
   endtask

   task automatic waitRx(input int target, input string tag);
      int n = 0;
      while (rxReads < target && n < 3000) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (rxReads < target) checkOutput(tag, rxReads, target);
   endtask

   task automatic waitPops(input int target, input string tag);
      int n = 0;
      while (popQ.size() < target && n < 3000) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (popQ.size() < target) checkOutput(tag, popQ.size(), target);
   endtask

   task automatic waitWrites(input int target, input string tag);
      int n = 0;
      while (wrLog.size() < target && n < 3000) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (wrLog.size() < target) checkOutput(tag, wrLog.size(), target);
   endtask

   task automatic waitLevel(input int target, input string tag);
      int n = 0;
      while (int'(fifoLevel) != target && n < 3000) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (int'(fifoLevel) != target) checkOutput(tag, fifoLevel, target);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int pm;
      int rm;
      int sm;
      int tm;
      int wm;
      int n;

      idle(3);
      checkOutput("rst_address", avm_address, 5'd0);
      checkOutput("rst_read", avm_read, 1'b0);
      checkOutput("rst_write", avm_write, 1'b0);
      checkOutput("rst_writedata", avm_writedata, 32'h0);
      checkOutput("rst_valid", pixValid, 1'b0);
      checkOutput("rst_level", fifoLevel, 3'd0);
      checkOutput("rst_pixdata", pixData, 24'h0);
      checkOutput("rst_last", pixLast, 1'b0);
      checkOutput("rst_framedone", frameDone, 1'b0);
      rst_n = 1'b1;

      $display("[TB] three-byte pixel assembly");
      applyStimulus(8'h12);
      applyStimulus(8'h34);
      waitRx(2, "asm_rx2_timeout");
      waitWrites(2, "asm_echo_timeout");
      idle(20);
      checkOutput("asm_two_bytes_no_valid", pixValid, 1'b0);
      checkOutput("asm_two_bytes_level", fifoLevel, 3'd0);
      checkOutput("asm_echo0", wrLog[0], 32'h00000012);
      checkOutput("asm_echo1", wrLog[1], 32'h00000034);
      applyStimulus(8'h56);
      waitRx(3, "asm_rx3_timeout");
      idle(5);
      checkOutput("asm_valid", pixValid, 1'b1);
      checkOutput("asm_pixdata", pixData, 24'h123456);
      checkOutput("asm_level", fifoLevel, 3'd1);
      checkOutput("asm_latency", validRiseCycle - lastRxCycle, 2);
      pm = popQ.size();
      pixReady = 1'b1;
      waitPops(pm + 1, "asm_pop_timeout");
      checkOutput("asm_popped", popQ[pm], 24'h123456);

      $display("[TB] status polling with rx_ready low");
      idle(10);
      sm = statReads - txStatReads;
      rm = rxReads;
      pm = popQ.size();
      rxHold = 5;
      applyStimulus(8'hA5);
      applyStimulus(8'hB6);
      applyStimulus(8'hC7);
      waitRx(rm + 1, "poll_rx_timeout");
      checkOutput("poll_status_reads", (statReads - txStatReads) - sm, 6);
      checkOutput("poll_first_rx_reads", rxReads - rm, 1);
      waitRx(rm + 3, "poll_rx3_timeout");
      waitPops(pm + 1, "poll_pop_timeout");
      checkOutput("poll_pixel", popQ[pm], 24'hA5B6C7);

      $display("[TB] echo with tx_ready low");
      idle(30);
      tm = txStatReads;
      wm = wrLog.size();
      pm = popQ.size();
      txHold = 2;
      applyStimulus(8'h5A);
      applyStimulus(8'h00);
      applyStimulus(8'hFF);
      waitWrites(wm + 3, "echo_wr_timeout");
      waitPops(pm + 1, "echo_pop_timeout");
      checkOutput("echo_first_txstat", txAtWr[wm] - tm, 3);
      checkOutput("echo_total_txstat", txStatReads - tm, 5);
      checkOutput("echo_data0", wrLog[wm], 32'h0000005A);
      checkOutput("echo_data1", wrLog[wm + 1], 32'h00000000);
      checkOutput("echo_data2", wrLog[wm + 2], 32'h000000FF);
      checkOutput("echo_pixel", popQ[pm], 24'h5A00FF);

      $display("[TB] waitrequest stalls");
      idle(20);
      stallCycles = 3;
      rm = rxReads;
      pm = popQ.size();
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      waitRx(rm + 3, "stall_rx_timeout");
      waitPops(pm + 1, "stall_pop_timeout");
      idle(40);
      checkOutput("stall_pixel", popQ[pm], 24'h112233);
      checkOutput("stall_rx_reads", rxReads - rm, 3);
      checkOutput("stall_stable", stableErr, 0);
      stallCycles = 0;

      $display("[TB] back-pressure with full FIFO");
      idle(20);
      pixReady = 1'b0;
      rm = rxReads;
      pm = popQ.size();
      for (int j = 0; j < 18; j++) applyStimulus(8'(j + 1));
      waitLevel(4, "bp_fill_timeout");
      idle(60);
      sm = statReads;
      idle(50);
      checkOutput("bp_level", fifoLevel, 3'd4);
      checkOutput("bp_rx_reads", rxReads - rm, 12);
      checkOutput("bp_no_status", statReads - sm, 0);
      checkOutput("bp_head", pixData, 24'h010203);
      pixReady = 1'b1;
      waitRx(rm + 18, "bp_drain_rx_timeout");
      waitPops(pm + 6, "bp_drain_pop_timeout");
      for (int i = 0; i < 6; i++)
         checkOutput($sformatf("bp_order%0d", i), popQ[pm + i], {8'(3 * i + 1), 8'(3 * i + 2), 8'(3 * i + 3)});
      idle(5);
      checkOutput("bp_level_empty", fifoLevel, 3'd0);

      $display("[TB] frame boundaries");
      idle(20);
      rst_n = 1'b0;
      idle(2);
      rxQ.delete();
      popIdx = 0;
      doneBits = '0;
      lastBits = '0;
      doneTotal = 0;
      pm = popQ.size();
      rst_n = 1'b1;
      for (int j = 0; j < 27; j++) applyStimulus(8'(j + 8'h40));
      waitPops(pm + 9, "frame_pop_timeout");
      idle(10);
      checkOutput("frame_pops", popIdx, 9);
      checkOutput("frame_done_bits", doneBits, 16'h0088);
      checkOutput("frame_last_bits", lastBits, 16'h0088);
      checkOutput("frame_done_total", doneTotal, 2);
      checkOutput("frame_pixel8", popQ[pm + 8], 24'h58595A);

      $display("[TB] reset during RX read");
      pixReady = 1'b0;
      stallCycles = 2;
      rm = rxReads;
      applyStimulus(8'h77);
      applyStimulus(8'h88);
      applyStimulus(8'h99);
      waitRx(rm + 3, "rrst_rx_timeout");
      waitLevel(1, "rrst_level_timeout");
      checkOutput("rrst_level_before", fifoLevel, 3'd1);
      applyStimulus(8'hEE);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!(avm_read && avm_address == 5'd0) && n < 500);
      checkOutput("rrst_in_rx_read", {avm_read, avm_address}, {1'b1, 5'd0});
      rm = rxReads;
      rst_n = 1'b0;
      #1;
      checkOutput("rrst_read", avm_read, 1'b0);
      checkOutput("rrst_write", avm_write, 1'b0);
      checkOutput("rrst_address", avm_address, 5'd0);
      checkOutput("rrst_valid", pixValid, 1'b0);
      checkOutput("rrst_level", fifoLevel, 3'd0);
      checkOutput("rrst_pixdata", pixData, 24'h0);
      checkOutput("rrst_last", pixLast, 1'b0);
      checkOutput("rrst_framedone", frameDone, 1'b0);
      idle(3);
      checkOutput("rrst_not_consumed", rxReads - rm, 0);
      rxQ.delete();
      stallCycles = 0;
      rst_n = 1'b1;
      idle(10);

      checkOutput("bus_read_write_overlap", bothErr, 0);
      checkOutput("bus_write_address", wrAddrErr, 0);
      checkOutput("bus_bad_reads", badRdErr, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
